// File: rtl/w0rm_alu_pkg.sv
// Shared constants for the w0rm ALU: opcode encodings, flag bit positions,
// and helpers that split shifter mux levels across pipeline stages.
package w0rm_alu_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int FLAGS_WIDTH  = 4;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_LSL = 4'd0;
    localparam opcode_t OP_LSR = 4'd1;
    localparam opcode_t OP_ASR = 4'd2;
    localparam opcode_t OP_ROR = 4'd3;
    localparam opcode_t OP_ROL = 4'd4;

    // result_flags = {V, C, N, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // First mux level handled by stage k; leftover levels land in stage 0.
    function automatic int stage_lo(input int k, input int levels, input int stages);
        int base;
        int extra;
        base  = levels / stages;
        extra = levels % stages;
        return (k == 0) ? 0 : (extra + k * base);
    endfunction

    // Last mux level handled by stage k.
    function automatic int stage_hi(input int k, input int levels, input int stages);
        int base;
        int extra;
        base  = levels / stages;
        extra = levels % stages;
        return (k == 0) ? (base + extra - 1) : (extra + k * base + base - 1);
    endfunction

endpackage

// File: rtl/w0rm_shift_stage.sv
// One pipeline stage of the logarithmic shifter. It applies mux levels
// LVL_LO..LVL_HI (plus the shift-by-DATA_WIDTH level when HAS_TOP) and,
// in the final stage, produces the {V,C,N,Z} flags.
// Optional feature macro: W0RM_SHIFT_ROTATE_EN (enables ROR/ROL datapath).
//
// Shifts run on a DATA_WIDTH+1 bit vector holding the data plus one guard
// bit on the side bits leave from, so the guard naturally ends up holding
// the last bit shifted out, and zero once the shift exceeds the width.
module w0rm_shift_stage
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_LO     = 0,
    parameter int LVL_HI     = 0,
    parameter bit HAS_TOP    = 1'b0,
    parameter bit IS_LAST    = 1'b0,
    localparam int LOG2W     = $clog2(DATA_WIDTH),
    localparam int AMT_WIDTH = LOG2W + 1
)(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    advance_i,
    input  logic                    valid_i,
    input  logic [OPCODE_WIDTH-1:0] op_i,
    input  logic [AMT_WIDTH-1:0]    amt_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    carry_i,
    input  logic [FLAGS_WIDTH-1:0]  flags_i,
    output logic                    valid_o,
    output logic [OPCODE_WIDTH-1:0] op_o,
    output logic [AMT_WIDTH-1:0]    amt_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    carry_o,
    output logic [FLAGS_WIDTH-1:0]  flags_o
);

    logic                    valid_q;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [AMT_WIDTH-1:0]    amt_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    carry_q;
    logic [FLAGS_WIDTH-1:0]  flags_q;

    logic [DATA_WIDTH-1:0]   data_d;
    logic                    carry_d;
    logic [FLAGS_WIDTH-1:0]  flags_d;
    logic [DATA_WIDTH:0]     ext_l_s;
    logic [DATA_WIDTH:0]     ext_r_s;
    logic [2*DATA_WIDTH-1:0] rot_s;
    logic                    carry_f_s;
    logic [FLAGS_WIDTH-1:0]  flags_calc_s;

    // Apply this stage's mux levels to the travelling operand.
    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        ext_l_s = {(DATA_WIDTH+1){1'b0}};
        ext_r_s = {(DATA_WIDTH+1){1'b0}};
        rot_s   = {(2*DATA_WIDTH){1'b0}};
        for (int j = 0; j <= LOG2W; j++) begin
            if ((((j >= LVL_LO) && (j <= LVL_HI)) || (HAS_TOP && (j == LOG2W))) && amt_i[j]) begin
                case (op_i)
                    OP_LSL: begin
                        ext_l_s = {carry_d, data_d} << (1 << j);
                        carry_d = ext_l_s[DATA_WIDTH];
                        data_d  = ext_l_s[DATA_WIDTH-1:0];
                    end
                    OP_LSR: begin
                        ext_r_s = {data_d, carry_d} >> (1 << j);
                        data_d  = ext_r_s[DATA_WIDTH:1];
                        carry_d = ext_r_s[0];
                    end
                    OP_ASR: begin
                        ext_r_s = $unsigned($signed({data_d, carry_d}) >>> (1 << j));
                        data_d  = ext_r_s[DATA_WIDTH:1];
                        carry_d = ext_r_s[0];
                    end
`ifdef W0RM_SHIFT_ROTATE_EN
                    // Rotates take the amount modulo DATA_WIDTH: skip the top level.
                    OP_ROR: begin
                        if (j < LOG2W) begin
                            rot_s  = {data_d, data_d} >> (1 << j);
                            data_d = rot_s[DATA_WIDTH-1:0];
                        end else begin
                            data_d = data_d;
                        end
                    end
                    OP_ROL: begin
                        if (j < LOG2W) begin
                            rot_s  = {data_d, data_d} << (1 << j);
                            data_d = rot_s[2*DATA_WIDTH-1:DATA_WIDTH];
                        end else begin
                            data_d = data_d;
                        end
                    end
`endif
                    default: begin
                        data_d = data_d;
                    end
                endcase
            end else begin
                data_d = data_d;
            end
        end
    end

    // Flag generation; only the final stage produces real flags.
    always_comb begin
        carry_f_s = carry_d;
`ifdef W0RM_SHIFT_ROTATE_EN
        if ((op_i == OP_ROR) && (amt_i != {AMT_WIDTH{1'b0}})) begin
            carry_f_s = data_d[DATA_WIDTH-1];
        end else if ((op_i == OP_ROL) && (amt_i != {AMT_WIDTH{1'b0}})) begin
            carry_f_s = data_d[0];
        end else begin
            carry_f_s = carry_d;
        end
`endif
        flags_calc_s         = {FLAGS_WIDTH{1'b0}};
        flags_calc_s[FLAG_C] = carry_f_s;
        flags_calc_s[FLAG_N] = data_d[DATA_WIDTH-1];
        flags_calc_s[FLAG_Z] = (data_d == {DATA_WIDTH{1'b0}});
        flags_calc_s[FLAG_V] = 1'b0;
        if (IS_LAST) begin
            flags_d = flags_calc_s;
        end else begin
            flags_d = flags_i;
        end
    end

    // Stage register: cleared on reset, frozen while the pipe is stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            op_q    <= {OPCODE_WIDTH{1'b0}};
            amt_q   <= {AMT_WIDTH{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            carry_q <= 1'b0;
            flags_q <= {FLAGS_WIDTH{1'b0}};
        end else if (advance_i) begin
            valid_q <= valid_i;
            op_q    <= op_i;
            amt_q   <= amt_i;
            data_q  <= data_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign amt_o   = amt_q;
    assign data_o  = data_q;
    assign carry_o = carry_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/w0rm_alu_barrel_shift.sv
// Pipelined barrel shifter (LSL/LSR/ASR, optional ROR/ROL) with a
// valid/ready handshake on both sides. The whole pipe advances together
// and freezes when a result is waiting but not accepted.
// Optional feature macro: W0RM_SHIFT_ROTATE_EN (enables ROR/ROL).
module w0rm_alu_barrel_shift
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   data_a,
    input  logic [DATA_WIDTH-1:0]   data_b,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [FLAGS_WIDTH-1:0]  result_flags
);

    localparam int LOG2W     = $clog2(DATA_WIDTH);
    localparam int AMT_WIDTH = LOG2W + 1;

    logic                    valid_s [0:PIPE_STAGES];
    logic [OPCODE_WIDTH-1:0] op_s    [0:PIPE_STAGES];
    logic [AMT_WIDTH-1:0]    amt_s   [0:PIPE_STAGES];
    logic [DATA_WIDTH-1:0]   data_s  [0:PIPE_STAGES];
    logic                    carry_s [0:PIPE_STAGES];
    logic [FLAGS_WIDTH-1:0]  flags_s [0:PIPE_STAGES];
    logic                    advance_s;
    logic                    unused_s;

    assign advance_s  = !(valid_s[PIPE_STAGES] && !result_ready);
    assign data_ready = advance_s;

    assign valid_s[0] = data_valid;
    assign op_s[0]    = opcode;
    assign amt_s[0]   = data_b[AMT_WIDTH-1:0];
    assign data_s[0]  = data_a;
    assign carry_s[0] = 1'b0;
    assign flags_s[0] = {FLAGS_WIDTH{1'b0}};

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        w0rm_shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .LVL_LO     (stage_lo(k, LOG2W, PIPE_STAGES)),
            .LVL_HI     (stage_hi(k, LOG2W, PIPE_STAGES)),
            .HAS_TOP    (k == 0),
            .IS_LAST    (k == PIPE_STAGES - 1)
        ) u_stage (
            .clk_i     (clk),
            .reset_i   (reset),
            .advance_i (advance_s),
            .valid_i   (valid_s[k]),
            .op_i      (op_s[k]),
            .amt_i     (amt_s[k]),
            .data_i    (data_s[k]),
            .carry_i   (carry_s[k]),
            .flags_i   (flags_s[k]),
            .valid_o   (valid_s[k+1]),
            .op_o      (op_s[k+1]),
            .amt_o     (amt_s[k+1]),
            .data_o    (data_s[k+1]),
            .carry_o   (carry_s[k+1]),
            .flags_o   (flags_s[k+1])
        );
    end

    assign result_valid = valid_s[PIPE_STAGES];
    assign result       = data_s[PIPE_STAGES];
    assign result_flags = flags_s[PIPE_STAGES];

    // Sideband that leaves the last stage plus ignored amount bits.
    assign unused_s = ^{op_s[PIPE_STAGES], amt_s[PIPE_STAGES], carry_s[PIPE_STAGES],
                        data_b[DATA_WIDTH-1:AMT_WIDTH]};

endmodule

// File: tb/tb_w0rm_alu_barrel_shift.sv
// Bench for w0rm_alu_barrel_shift: three instances (8-bit/2 stages,
// 32-bit/1 stage, 32-bit/3 stages) share one stimulus stream; each is
// checked cycle by cycle against a behavioural model and a timing queue.
module tb_w0rm_alu_barrel_shift;

    typedef struct packed {
        int unsigned due;
        logic [3:0]  flags;
        logic [63:0] res;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        data_valid;
    logic        result_ready;
    logic [3:0]  opcode;
    logic [63:0] data_a;
    logic [63:0] data_b;

    logic        dr8, rv8, dr32a, rv32a, dr32b, rv32b;
    logic [7:0]  res8;
    logic [31:0] res32a, res32b;
    logic [3:0]  fl8, fl32a, fl32b;

    logic        rv_a  [0:2];
    logic        dr_a  [0:2];
    logic [63:0] res_a [0:2];
    logic [3:0]  fl_a  [0:2];

    exp_t        exp_q [0:2][$];
    int          checks;
    int          failures;
    int          cyc;
    int          pops  [0:2];
    logic        accepted [0:2];

    w0rm_alu_barrel_shift #(.DATA_WIDTH(8), .PIPE_STAGES(2)) u_dut8 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_ready(dr8),
        .opcode(opcode), .data_a(data_a[7:0]), .data_b(data_b[7:0]),
        .result(res8), .result_valid(rv8), .result_ready(result_ready),
        .result_flags(fl8));

    w0rm_alu_barrel_shift #(.DATA_WIDTH(32), .PIPE_STAGES(1)) u_dut32a (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_ready(dr32a),
        .opcode(opcode), .data_a(data_a[31:0]), .data_b(data_b[31:0]),
        .result(res32a), .result_valid(rv32a), .result_ready(result_ready),
        .result_flags(fl32a));

    w0rm_alu_barrel_shift #(.DATA_WIDTH(32), .PIPE_STAGES(3)) u_dut32b (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_ready(dr32b),
        .opcode(opcode), .data_a(data_a[31:0]), .data_b(data_b[31:0]),
        .result(res32b), .result_valid(rv32b), .result_ready(result_ready),
        .result_flags(fl32b));

    assign rv_a[0] = rv8;   assign dr_a[0] = dr8;   assign res_a[0] = {56'd0, res8};   assign fl_a[0] = fl8;
    assign rv_a[1] = rv32a; assign dr_a[1] = dr32a; assign res_a[1] = {32'd0, res32a}; assign fl_a[1] = fl32a;
    assign rv_a[2] = rv32b; assign dr_a[2] = dr32b; assign res_a[2] = {32'd0, res32b}; assign fl_a[2] = fl32b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wk(input int k);
        return (k == 0) ? 8 : 32;
    endfunction

    function automatic int pk(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: shift semantics written straight from the operation rules.
    function automatic logic [63:0] ref_shift(input int w, input logic [3:0] op,
                                              input logic [63:0] a_in, input logic [63:0] b_in,
                                              output logic [3:0] flags);
        logic [63:0] a, r;
        logic        c, sign;
        int          n, m;
        a    = a_in & wmask(w);
        n    = int'(b_in[6:0]) % (2 * w);
        sign = a[w-1];
        r    = a;
        c    = 1'b0;
        case (op)
            4'd0: if (n > 0 && n <= w) begin r = (a << n) & wmask(w); c = a[w-n]; end
                  else if (n > w) begin r = 64'd0; end
            4'd1: if (n > 0 && n <= w) begin r = a >> n; c = a[n-1]; end
                  else if (n > w) begin r = 64'd0; end
            4'd2: if (n >= w) begin r = sign ? wmask(w) : 64'd0; c = sign; end
                  else if (n > 0) begin
                      r = 64'd0;
                      for (int i = 0; i < w; i++) r[i] = (i + n < w) ? a[i+n] : sign;
                      c = a[n-1];
                  end
`ifdef W0RM_SHIFT_ROTATE_EN
            4'd3, 4'd4: begin
                m = n % w;
                r = 64'd0;
                for (int i = 0; i < w; i++) r[i] = (op == 4'd3) ? a[(i + m) % w] : a[(i - m + w) % w];
                if (n != 0) c = (op == 4'd3) ? r[w-1] : r[0];
            end
`endif
            default: begin r = a; c = 1'b0; end
        endcase
        flags = {1'b0, c, r[w-1], (r == 64'd0)};
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%h expected=%h (cycle %0d)", name, k, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check every instance against its model.
    task automatic run_cycle(input logic dv, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic rr, input logic rst);
        exp_t       e;
        logic       ev;
        logic [3:0] fl;
        @(negedge clk);
        reset = rst; data_valid = dv; opcode = op; data_a = a; data_b = b; result_ready = rr;
        #1;
        for (int k = 0; k < 3; k++) begin
            accepted[k] = 1'b0;
            if (rst) begin
                exp_q[k].delete();
            end else begin
                ev = (exp_q[k].size() > 0) && (exp_q[k][0].due <= cyc);
                chk("result_valid", k, {63'd0, rv_a[k]}, {63'd0, ev});
                chk("data_ready", k, {63'd0, dr_a[k]}, {63'd0, !(ev && !rr)});
                if (ev) begin
                    chk("result", k, res_a[k], exp_q[k][0].res);
                    chk("result_flags", k, {60'd0, fl_a[k]}, {60'd0, exp_q[k][0].flags});
                end
                if (dv && !(ev && !rr)) begin
                    e.res   = ref_shift(wk(k), op, a, b, fl);
                    e.flags = fl;
                    e.due   = cyc + pk(k);
                    exp_q[k].push_back(e);
                    accepted[k] = 1'b1;
                end
                if (ev && rr) begin
                    void'(exp_q[k].pop_front());
                    pops[k]++;
                end else if (ev) begin
                    for (int i = 1; i < exp_q[k].size(); i++) exp_q[k][i].due = exp_q[k][i].due + 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        logic        have_op;
        int          acc8, pops_start;
        int          amts [0:5];

        checks = 0; failures = 0; cyc = 0;
        for (int k = 0; k < 3; k++) pops[k] = 0;
        reset = 1'b1; data_valid = 1'b0; opcode = 4'd0; data_a = 64'd0; data_b = 64'd0;
        result_ready = 1'b1;

        // Reset, then reset state of every instance.
        run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b1);
        run_cycle(1'b1, 4'd0, 64'hFF, 64'd1, 1'b1, 1'b1);
        run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("reset_result", k, res_a[k], 64'd0);
            chk("reset_flags", k, {60'd0, fl_a[k]}, 64'd0);
        end

        // LSL 0x81 by 1 on the 8-bit instance.
        run_cycle(1'b1, 4'd0, 64'h81, 64'd1, 1'b1, 1'b0);
        idle(1);
        chk("lsl81_early_valid", 0, {63'd0, rv8}, 64'd0);
        idle(1);
        chk("lsl81_res", 0, {56'd0, res8}, 64'h02);
        chk("lsl81_flags", 0, {60'd0, fl8}, 64'h4);

        // ASR and LSR 0x80 by 9.
        run_cycle(1'b1, 4'd2, 64'h80, 64'd9, 1'b1, 1'b0);
        run_cycle(1'b1, 4'd1, 64'h80, 64'd9, 1'b1, 1'b0);
        run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        chk("asr80_res", 0, {56'd0, res8}, 64'hFF);
        chk("asr80_flags", 0, {60'd0, fl8}, 64'h6);
        run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        chk("lsr80_res", 0, {56'd0, res8}, 64'h00);
        chk("lsr80_flags", 0, {60'd0, fl8}, 64'h1);
        idle(2);

        // ROR 0x01 by 9 (reserved when rotate is compiled out).
        run_cycle(1'b1, 4'd3, 64'h01, 64'd9, 1'b1, 1'b0);
        idle(2);
`ifdef W0RM_SHIFT_ROTATE_EN
        chk("ror01_res", 0, {56'd0, res8}, 64'h80);
        chk("ror01_flags", 0, {60'd0, fl8}, 64'h6);
`else
        chk("op3_res", 0, {56'd0, res8}, 64'h01);
        chk("op3_flags", 0, {60'd0, fl8}, 64'h0);
`endif
        idle(2);

        // LSL 1 by 31: latency 1 and 3 on the 32-bit instances.
        run_cycle(1'b1, 4'd0, 64'h1, 64'd31, 1'b1, 1'b0);
        idle(1);
        chk("p1_valid", 1, {63'd0, rv32a}, 64'd1);
        chk("p1_res", 1, {32'd0, res32a}, 64'h8000_0000);
        chk("p1_flags", 1, {60'd0, fl32a}, 64'h2);
        chk("p3_early_valid", 2, {63'd0, rv32b}, 64'd0);
        idle(2);
        chk("p3_valid", 2, {63'd0, rv32b}, 64'd1);
        chk("p3_res", 2, {32'd0, res32b}, 64'h8000_0000);
        chk("p3_flags", 2, {60'd0, fl32b}, 64'h2);
        idle(2);

        // Boundary amounts for every opcode class, back to back.
        amts = '{0, 7, 8, 31, 32, 33};
        for (int o = 0; o < 6; o++) begin
            for (int j = 0; j < 6; j++) begin
                run_cycle(1'b1, (o == 5) ? 4'd9 : 4'(o), 64'hC3A5_0F81_8000_0001,
                          64'(amts[j]), 1'b1, 1'b0);
            end
        end
        idle(4);

        // Random stream of 16 ops, result_ready low for 3 cycles mid-stream.
        acc8 = 0; have_op = 1'b0; pops_start = pops[0];
        op = 4'd0; a = 64'd0; b = 64'd0;
        for (int t = 0; (t < 60) && (acc8 < 16); t++) begin
            if (!have_op) begin
                op = 4'($urandom_range(0, 7));
                a  = {$urandom, $urandom};
                b  = {$urandom, ($urandom & 32'hFFFF_FF80) | 32'($urandom_range(0, 127))};
                have_op = 1'b1;
            end
            run_cycle(1'b1, op, a, b, !((t >= 6) && (t <= 8)), 1'b0);
            if (accepted[0]) begin
                acc8++;
                have_op = 1'b0;
            end
        end
        idle(6);
        chk("stream_accepted", 0, 64'(acc8), 64'd16);
        chk("stream_delivered", 0, 64'(pops[0] - pops_start), 64'd16);
        for (int k = 0; k < 3; k++) chk("stream_drained", k, 64'(exp_q[k].size()), 64'd0);

        // Reset with operations in flight; data_valid high during reset.
        run_cycle(1'b1, 4'd0, 64'h1234_5678, 64'd3, 1'b1, 1'b0);
        run_cycle(1'b1, 4'd1, 64'h8765_4321, 64'd5, 1'b1, 1'b0);
        run_cycle(1'b1, 4'd2, 64'hFFFF_0000, 64'd2, 1'b1, 1'b1);
        run_cycle(1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("rst_mid_result", k, res_a[k], 64'd0);
            chk("rst_mid_flags", k, {60'd0, fl_a[k]}, 64'd0);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w0rm_alu_barrel_shift.md
W0RM_ALU_BARREL_SHIFT -- requirements
Module: w0rm_alu_barrel_shift

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, register stages from accepted input to result_valid; legal 1..log2(DATA_WIDTH).
REQ-003 SHALL have port clk input 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have port data_valid input 1: input operation offered.
REQ-006 SHALL have port data_ready output 1: block accepts the offered operation this cycle.
REQ-007 SHALL have port opcode input 4: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 ROL; others reserved.
REQ-008 SHALL have port data_a input DATA_WIDTH: value to shift.
REQ-009 SHALL have port data_b input DATA_WIDTH: shift amount; only bits [log2(DATA_WIDTH):0] used, upper bits ignored.
REQ-010 SHALL have port result output DATA_WIDTH: shifted value.
REQ-011 SHALL have port result_valid output 1: result/result_flags valid.
REQ-012 SHALL have port result_ready input 1: consumer accepts the result this cycle.
REQ-013 SHALL have port result_flags output 4: {V, C, N, Z}.

Function
REQ-014 SHALL accept an operation on a cycle where data_valid && data_ready; no other cycle loads the pipe.
REQ-015 SHALL present the result exactly PIPE_STAGES cycles after acceptance when result_ready is held high.
REQ-016 SHALL sustain one operation per cycle with no bubbles while result_ready is high.
REQ-017 SHALL stall the whole pipe when result_valid && !result_ready; data_ready = !(result_valid && !result_ready); result, result_flags held stable while stalled.
REQ-018 SHALL distribute the log2(DATA_WIDTH) mux levels of a logarithmic shifter evenly across PIPE_STAGES; leftover levels go to the first stage.
REQ-019 SHALL, for shift amount 0, return data_a unchanged with C = 0.
REQ-020 SHALL, for LSL/LSR with amount 1..DATA_WIDTH, set C to the last bit shifted out; for amount > DATA_WIDTH, result = 0 and C = 0.
REQ-021 SHALL, for ASR with amount >= DATA_WIDTH, fill result with data_a MSB and set C = data_a MSB.
REQ-022 SHALL, for ROR/ROL, use amount modulo DATA_WIDTH; C = result MSB (ROR) or result LSB (ROL) when amount != 0.
REQ-023 SHALL set N = result MSB, Z = (result == 0), V = 0 always.
REQ-024 SHALL, for reserved opcodes, return data_a unchanged with C = 0, N/Z computed normally.
REQ-025 SHALL keep the opcode/amount/valid bits travelling with data in every stage; no operand is sampled after acceptance.

Reset
REQ-026 SHALL, on reset, clear all stage valid bits; result_valid = 0, result = 0, result_flags = 0, data_ready = 1 on the cycle after reset deasserts.
REQ-027 SHALL discard any in-flight operations on reset mid-operation; none emerge afterwards.
REQ-028 SHALL ignore data_valid while reset is high.

Configuration
REQ-029 SHALL, with W0RM_SHIFT_ROTATE_EN defined, implement ROR and ROL per REQ-022.
REQ-030 SHALL, without W0RM_SHIFT_ROTATE_EN, treat opcodes 3 and 4 as reserved (REQ-024) and omit the rotate wrap-around datapath.

Structure
REQ-031 SHALL take opcode encodings, flag bit indices and OPCODE_WIDTH/FLAGS_WIDTH constants from the shared package w0rm_alu_pkg.
REQ-032 SHALL instantiate one sub-module w0rm_shift_stage (parametrised by level range) per pipe stage; flag generation in the final stage.

Verification
REQ-033 DATA_WIDTH=8, LSL a=0x81 b=1 -> result 0x02, C=1, N=0, Z=0, after PIPE_STAGES cycles.
REQ-034 DATA_WIDTH=8, ASR a=0x80 b=9 -> result 0xFF, C=1, N=1, Z=0; LSR a=0x80 b=9 -> 0x00, C=0, Z=1.
REQ-035 Rotate on, ROR a=0x01 b=9 -> 0x80, C=1, N=1; rotate off, opcode 3 a=0x01 -> 0x01, C=0.
REQ-036 Back-to-back 16 random ops with result_ready low for 3 cycles mid-stream -> all 16 results in order, none lost/duplicated, outputs stable during stall.
REQ-037 Assert reset with 2 ops in flight -> result_valid=0 next cycle, no stale result emerges afterward.
REQ-038 PIPE_STAGES=1 and =3, DATA_WIDTH=32, LSL a=0x1 b=31 -> 0x80000000, N=1 at latency 1 and 3 respectively.
